// File: rtl/rpn_lan_seq_num_initializer_if.sv
// AXI-Stream link carrying both the SEQ_NUM_CHECK requests and the SEQ_NUM_REPLY stream.
// The master drives the payload and tvalid; the slave drives tready.
interface rpn_lan_seq_num_initializer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic [ID_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;

    modport master (
        output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/rpn_lan_seq_num_initializer.sv
// Walks every remote peer once per start: sends SEQ_NUM_CHECK, waits for the matching
// SEQ_NUM_REPLY and writes the returned sequence number into the LAN TX seq-num table.
module rpn_lan_seq_num_initializer #(
    parameter int unsigned AXIS_DATA_WIDTH          = 64,
    parameter int unsigned AXIS_KEEP_WIDTH          = 8,
    parameter int unsigned AXIS_FROM_NB_TDEST_WIDTH = 8,
    parameter int unsigned AXIS_FROM_NB_TUSER_WIDTH = 16,
    parameter int unsigned RPN_MSG_TYPE_WIDTH       = 2,
    parameter int unsigned RPN_SEQ_NUM_WIDTH        = 16,
    parameter int unsigned NUM_PEERS                = 16,
    parameter int unsigned LOCAL_ID                 = 0,
    parameter int unsigned TIMEOUT_CYCLES           = 1024,
    parameter int unsigned MAX_RETRIES              = 3
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst,
    input  logic                                i_init_start,
    rpn_lan_seq_num_initializer_if.slave        from_splitter,
    rpn_lan_seq_num_initializer_if.master       to_network_bridge,
    output logic                                o_seq_wr_en,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] o_seq_wr_peer,
    output logic [RPN_SEQ_NUM_WIDTH-1:0]        o_seq_wr_num,
    output logic                                o_busy,
    output logic                                o_init_done,
    output logic                                o_init_fail,
    output logic                                o_stray_reply
);
    localparam int unsigned PEER_W  = $clog2(NUM_PEERS + 1);
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned ID_W    = AXIS_FROM_NB_TDEST_WIDTH;

    localparam logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_SEQ_NUM_CHECK = RPN_MSG_TYPE_WIDTH'(2);
    localparam logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_SEQ_NUM_REPLY = RPN_MSG_TYPE_WIDTH'(3);
    localparam logic [PEER_W-1:0]  PEER_END    = PEER_W'(NUM_PEERS);
    localparam logic [PEER_W-1:0]  PEER_LOCAL  = PEER_W'(LOCAL_ID);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {StIdle, StSelect, StSend, StWait, StDone, StFail} state_e;

    state_e                         r_state;
    state_e                         w_state_next;
    logic [PEER_W-1:0]              r_peer;
    logic [TIMER_W-1:0]             r_timer;
    logic [RETRY_W-1:0]             r_retries;
    logic                           r_in_pkt;
    logic                           r_wr_en;
    logic [ID_W-1:0]                r_wr_peer;
    logic [RPN_SEQ_NUM_WIDTH-1:0]   r_wr_num;
    logic                           r_stray;

    logic                           w_rx_fire;
    logic                           w_rx_first;
    logic [RPN_MSG_TYPE_WIDTH-1:0]  w_rx_type;
    logic [RPN_SEQ_NUM_WIDTH-1:0]   w_rx_seq;
    logic                           w_match;
    logic                           w_timeout;
    logic                           w_start;
    logic                           w_unused_rx;

    // The reply sink never back-pressures the splitter.
    assign from_splitter.tready = !i_ap_rst;

    assign w_rx_fire  = from_splitter.tvalid && from_splitter.tready;
    assign w_rx_first = w_rx_fire && !r_in_pkt;
    assign w_rx_type  = from_splitter.tdata[RPN_MSG_TYPE_WIDTH-1:0];
    assign w_rx_seq   = from_splitter.tdata[RPN_MSG_TYPE_WIDTH +: RPN_SEQ_NUM_WIDTH];
    assign w_match    = w_rx_first && (r_state == StWait)
                        && (from_splitter.tid == ID_W'(r_peer))
                        && (w_rx_type == MSG_SEQ_NUM_REPLY);
    assign w_timeout  = (r_state == StWait) && (r_timer == TIMER_LAST);
    assign w_start    = i_init_start
                        && ((r_state == StIdle) || (r_state == StDone) || (r_state == StFail));

    assign w_unused_rx = ^{from_splitter.tkeep, from_splitter.tdest, from_splitter.tuser,
                           from_splitter.tdata};

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone, StFail: begin
                if (i_init_start) w_state_next = StSelect;
            end
            StSelect: begin
                if (r_peer == PEER_LOCAL) begin
                    w_state_next = StSelect;
                end else if (r_peer == PEER_END) begin
                    w_state_next = StDone;
                end else begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (to_network_bridge.tready) w_state_next = StWait;
            end
            StWait: begin
                // A reply landing on the timeout cycle still counts.
                if (w_match) begin
                    w_state_next = StSelect;
                end else if (w_timeout) begin
                    w_state_next = (r_retries < RETRY_LIMIT) ? StSend : StFail;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            r_peer    <= '0;
            r_timer   <= '0;
            r_retries <= '0;
            r_in_pkt  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_peer <= '0;
            r_wr_num  <= '0;
            r_stray   <= 1'b0;
        end else begin
            r_wr_en <= w_match;
            r_stray <= w_rx_first && !w_match;
            if (w_match) begin
                r_wr_peer <= ID_W'(r_peer);
                r_wr_num  <= w_rx_seq;
            end
            if (w_rx_fire) r_in_pkt <= !from_splitter.tlast;

            if (w_start) begin
                r_peer    <= '0;
                r_retries <= '0;
            end else if ((r_state == StSelect) && (r_peer == PEER_LOCAL)) begin
                r_peer <= r_peer + PEER_W'(1);
            end else if (w_match) begin
                r_peer    <= r_peer + PEER_W'(1);
                r_retries <= '0;
            end else if (w_timeout && (r_retries < RETRY_LIMIT)) begin
                r_retries <= r_retries + RETRY_W'(1);
            end

            if (r_state == StSend) begin
                r_timer <= '0;
            end else if (r_state == StWait) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

    always_comb begin
        to_network_bridge.tvalid = 1'b0;
        to_network_bridge.tdata  = '0;
        to_network_bridge.tkeep  = '0;
        to_network_bridge.tid    = '0;
        to_network_bridge.tdest  = '0;
        to_network_bridge.tuser  = '0;
        to_network_bridge.tlast  = 1'b0;
        o_busy                   = 1'b0;
        o_init_done              = 1'b0;
        o_init_fail              = 1'b0;
        unique case (r_state)
            StSelect, StWait: o_busy = 1'b1;
            StSend: begin
                o_busy                   = 1'b1;
                to_network_bridge.tvalid = 1'b1;
                to_network_bridge.tdata  = AXIS_DATA_WIDTH'(MSG_SEQ_NUM_CHECK);
                to_network_bridge.tkeep  = '1;
                to_network_bridge.tid    = ID_W'(LOCAL_ID);
                to_network_bridge.tdest  = ID_W'(r_peer);
                to_network_bridge.tlast  = 1'b1;
            end
            StDone:  o_init_done = 1'b1;
            StFail:  o_init_fail = 1'b1;
            default: ;
        endcase
    end

    assign o_seq_wr_en   = r_wr_en;
    assign o_seq_wr_peer = r_wr_peer;
    assign o_seq_wr_num  = r_wr_num;
    assign o_stray_reply = r_stray;
endmodule

// File: tb/tb_rpn_lan_seq_num_initializer.sv
// Randomised bench: a per-walk reply plan drives a bridge/splitter responder, and a
// peer-by-peer model of the walk predicts requests, table writes, strays and final status.
module tb_rpn_lan_seq_num_initializer;
    localparam int unsigned DW  = 64;
    localparam int unsigned KW  = 8;
    localparam int unsigned IW  = 8;
    localparam int unsigned UW  = 16;
    localparam int unsigned SW  = 16;
    localparam int unsigned NP  = 4;
    localparam int unsigned LID = 1;
    localparam int unsigned TO  = 16;
    localparam int unsigned MR  = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic wr_en;
    logic [IW-1:0] wr_peer;
    logic [SW-1:0] wr_num;
    logic busy, done, fail, stray;

    always #5 clk = ~clk;

    rpn_lan_seq_num_initializer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
                                     .USER_WIDTH(UW)) rx_if ();
    rpn_lan_seq_num_initializer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
                                     .USER_WIDTH(UW)) tx_if ();

    rpn_lan_seq_num_initializer #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_FROM_NB_TDEST_WIDTH(IW),
        .AXIS_FROM_NB_TUSER_WIDTH(UW), .RPN_MSG_TYPE_WIDTH(2), .RPN_SEQ_NUM_WIDTH(SW),
        .NUM_PEERS(NP), .LOCAL_ID(LID), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
    ) dut (
        .i_clk            (clk),
        .i_ap_rst         (rst),
        .i_init_start     (start),
        .from_splitter    (rx_if),
        .to_network_bridge(tx_if),
        .o_seq_wr_en      (wr_en),
        .o_seq_wr_peer    (wr_peer),
        .o_seq_wr_num     (wr_num),
        .o_busy           (busy),
        .o_init_done      (done),
        .o_init_fail      (fail),
        .o_stray_reply    (stray)
    );

    typedef struct {
        int            at;
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reply plan, per peer and attempt.
    bit            pl_reply [NP][MR+1];
    int            pl_delay [NP][MR+1];
    int            pl_beats [NP][MR+1];
    bit            pl_stray [NP][MR+1];
    bit            pl_skind [NP][MR+1];
    int            pl_stall [NP][MR+1];
    logic [SW-1:0] pl_seq   [NP];

    int                  exp_req[$];
    logic [IW+SW-1:0]    exp_wr[$];
    int                  exp_stray;
    bit                  exp_fail;

    int                  got_req[$];
    int                  req_at[$];
    int                  req_stall[$];
    logic [IW+SW-1:0]    got_wr[$];
    beat_t               beat_q[$];
    int                  att_cnt[NP];
    int                  n_stray;
    int                  cyc = 0;
    bit                  mon_en = 1'b0;
    int                  stall_left = 0;
    int                  cur_stall = 0;
    bit                  prev_v = 1'b0;
    bit                  prev_r = 1'b0;
    logic [DW-1:0]       prev_data, hold_data;
    logic [IW-1:0]       prev_dest, prev_tid, hold_dest;
    logic [KW-1:0]       prev_keep;
    logic [UW-1:0]       prev_user;
    logic                prev_last;

    task automatic plan_all(input int d);
        for (int p = 0; p < NP; p++) begin
            pl_seq[p] = SW'(16'h10 + p);
            for (int a = 0; a <= MR; a++) begin
                pl_reply[p][a] = 1'b1;
                pl_delay[p][a] = d;
                pl_beats[p][a] = 1;
                pl_stray[p][a] = 1'b0;
                pl_skind[p][a] = 1'b0;
                pl_stall[p][a] = 0;
            end
        end
    endtask

    task automatic plan_random(input int reply_pct);
        for (int p = 0; p < NP; p++) begin
            pl_seq[p] = SW'($urandom);
            for (int a = 0; a <= MR; a++) begin
                pl_reply[p][a] = ($urandom_range(99) < reply_pct);
                pl_delay[p][a] = ($urandom_range(3) == 0) ? TO : $urandom_range(2, TO);
                pl_beats[p][a] = $urandom_range(1, 3);
                pl_stray[p][a] = $urandom_range(0, 1);
                pl_skind[p][a] = $urandom_range(0, 1);
                pl_stall[p][a] = $urandom_range(0, 2);
            end
        end
    endtask

    // Walk order: every peer except the local one; up to 1+MR attempts, first answered one wins.
    task automatic build_model();
        exp_req.delete();
        exp_wr.delete();
        exp_stray = 0;
        exp_fail  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            bit ok;
            ok = 1'b0;
            if (p != LID && !exp_fail) begin
                for (int a = 0; a <= MR && !ok; a++) begin
                    exp_req.push_back(p);
                    if (pl_stray[p][a]) exp_stray++;
                    if (pl_reply[p][a]) begin
                        exp_wr.push_back({IW'(p), pl_seq[p]});
                        ok = 1'b1;
                    end
                end
                if (!ok) exp_fail = 1'b1;
            end
        end
    endtask

    task automatic schedule(input int p, input int a);
        beat_t b;
        logic [DW-1:0] d;
        if (pl_stray[p][a]) begin
            d = {$urandom, $urandom};
            if (pl_skind[p][a]) begin
                b.tid   = IW'(p + 3);
                d[1:0]  = 2'd3;
            end else begin
                b.tid   = IW'(p);
                d[1:0]  = 2'($urandom_range(0, 2));
            end
            b.at = cyc + 1; b.data = d; b.last = 1'b1;
            beat_q.push_back(b);
        end
        if (pl_reply[p][a]) begin
            for (int i = 0; i < pl_beats[p][a]; i++) begin
                d = {$urandom, $urandom};
                if (i == 0) begin
                    d[2 +: SW] = pl_seq[p];
                    d[1:0]     = 2'd3;
                    b.tid      = IW'(p);
                end else begin
                    b.tid = IW'($urandom);
                end
                b.at = cyc + pl_delay[p][a] + i;
                b.data = d;
                b.last = (i == pl_beats[p][a] - 1);
                beat_q.push_back(b);
            end
        end
    endtask

    // Bridge/splitter responder and monitor, run just after every rising edge.
    task automatic step();
        int    p;
        beat_t b;
        if (!rst) check("rx_tready_high", 64'(rx_if.tready), 64'd1);
        if (mon_en && !rst) begin
            if (wr_en) got_wr.push_back({wr_peer, wr_num});
            if (stray) n_stray++;
            if (prev_v && prev_r) begin
                p = int'(prev_dest);
                got_req.push_back(p);
                req_at.push_back(cyc);
                req_stall.push_back(cur_stall);
                check("req_tdata", prev_data, 64'd2);
                check("req_tid", 64'(prev_tid), 64'(LID));
                check("req_tkeep", 64'(prev_keep), 64'hFF);
                check("req_tuser", 64'(prev_user), 64'd0);
                check("req_tlast", 64'(prev_last), 64'd1);
                if (p < NP) begin
                    if (att_cnt[p] <= MR) schedule(p, att_cnt[p]);
                    att_cnt[p]++;
                end
            end
            if (prev_v && !prev_r) check("hold_tvalid", 64'(tx_if.tvalid), 64'd1);
            if (tx_if.tvalid) begin
                if (!prev_v || prev_r) begin
                    hold_dest = tx_if.tdest;
                    hold_data = tx_if.tdata;
                    p = int'(tx_if.tdest);
                    cur_stall = (p < NP && att_cnt[p] <= MR) ? pl_stall[p][att_cnt[p]] : 0;
                    stall_left = cur_stall;
                end else begin
                    check("hold_tdest", 64'(tx_if.tdest), 64'(hold_dest));
                    check("hold_tdata", tx_if.tdata, hold_data);
                end
            end
            tx_if.tready = tx_if.tvalid && (stall_left == 0);
            if (tx_if.tvalid && stall_left > 0) stall_left--;
            prev_v    = tx_if.tvalid;
            prev_r    = tx_if.tready;
            prev_data = tx_if.tdata;
            prev_dest = tx_if.tdest;
            prev_tid  = tx_if.tid;
            prev_keep = tx_if.tkeep;
            prev_user = tx_if.tuser;
            prev_last = tx_if.tlast;
        end else begin
            prev_v = 1'b0;
            prev_r = 1'b0;
            tx_if.tready = 1'b0;
        end
        while (beat_q.size() > 0 && beat_q[0].at <= cyc) void'(beat_q.pop_front());
        if (beat_q.size() > 0 && beat_q[0].at == cyc + 1) begin
            b = beat_q.pop_front();
            rx_if.tvalid = 1'b1;
            rx_if.tid    = b.tid;
            rx_if.tdata  = b.data;
            rx_if.tlast  = b.last;
            rx_if.tkeep  = '1;
            rx_if.tdest  = IW'($urandom);
            rx_if.tuser  = UW'($urandom);
        end else begin
            rx_if.tvalid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            step();
        end
    end

    task automatic clear_obs();
        got_req.delete();
        req_at.delete();
        req_stall.delete();
        got_wr.delete();
        beat_q.delete();
        for (int p = 0; p < NP; p++) att_cnt[p] = 0;
        n_stray = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_walk(input string name, input bit poke);
        int i;
        build_model();
        clear_obs();
        mon_en = 1'b1;
        @(negedge clk);
        pulse_start();
        check({name, "_busy_at_start"}, 64'(busy), 64'd1);
        if (poke) begin
            repeat ($urandom_range(10, 60)) @(negedge clk);
            if (busy) pulse_start();
        end
        for (i = 0; i < 3000 && !(done || fail); i++) @(negedge clk);
        if (!(done || fail)) check({name, "_walk_ends"}, 64'd0, 64'd1);
        repeat (4) @(negedge clk);
        check({name, "_done"}, 64'(done), 64'(!exp_fail));
        check({name, "_fail"}, 64'(fail), 64'(exp_fail));
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_req_count"}, 64'(got_req.size()), 64'(exp_req.size()));
        for (int k = 0; k < exp_req.size() && k < got_req.size(); k++)
            check($sformatf("%s_req_peer[%0d]", name, k), 64'(got_req[k]), 64'(exp_req[k]));
        for (int k = 1; k < got_req.size(); k++)
            if (got_req[k] == got_req[k-1])
                check($sformatf("%s_retry_gap[%0d]", name, k), 64'(req_at[k] - req_at[k-1]),
                      64'(TO + 1 + req_stall[k]));
        check({name, "_wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++)
            check($sformatf("%s_wr[%0d]", name, k), 64'(got_wr[k]), 64'(exp_wr[k]));
        check({name, "_stray_count"}, 64'(n_stray), 64'(exp_stray));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    base, npkt, len;
        rst = 1'b1;
        start = 1'b0;
        rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tkeep = '0; rx_if.tid = '0;
        rx_if.tdest = '0; rx_if.tuser = '0; rx_if.tlast = 1'b0;
        tx_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_stray", 64'(stray), 64'd0);
        check("rst_tx_tvalid", 64'(tx_if.tvalid), 64'd0);
        check("rst_rx_tready", 64'(rx_if.tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Every reply 5 cycles after acceptance; first request stalled 20 cycles.
        plan_all(5);
        pl_stall[0][0] = 20;
        run_walk("t1", 1'b0);
        check("t1_wr0", 64'(got_wr[0]), 64'h00_0010);
        check("t1_wr1", 64'(got_wr[1]), 64'h02_0012);
        check("t1_wr2", 64'(got_wr[2]), 64'h03_0013);
        check("t1_stall_len", 64'(req_stall[0]), 64'd20);

        // Peer 2 silent: four requests, then FAIL without reaching peer 3.
        plan_all(5);
        for (int a = 0; a <= MR; a++) pl_reply[2][a] = 1'b0;
        run_walk("t3", 1'b0);
        check("t3_fail", 64'(fail), 64'd1);

        // Peer 2 answers exactly on its timeout cycle.
        plan_all(4);
        pl_delay[2][0] = TO;
        run_walk("t4", 1'b0);

        // Stray tid=3 while waiting on peer 0, then a 3-beat reply.
        plan_all(6);
        pl_stray[0][0] = 1'b1;
        pl_skind[0][0] = 1'b1;
        pl_beats[0][0] = 3;
        run_walk("t5", 1'b0);
        check("t5_one_stray", 64'(n_stray), 64'd1);

        // Reset in the middle of SEND, then a clean walk from peer 0.
        plan_all(5);
        pl_stall[0][0] = 40;
        clear_obs();
        mon_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 10 && !tx_if.tvalid; i++) @(negedge clk);
        check("t6_send_reached", 64'(tx_if.tvalid), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_tvalid", 64'(tx_if.tvalid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_rx_tready", 64'(rx_if.tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        plan_all(7);
        run_walk("t6", 1'b0);

        for (int w = 0; w < 6; w++) begin
            plan_random((w < 3) ? 85 : 45);
            run_walk($sformatf("rnd%0d", w), w[0]);
        end

        // Packets arriving while the walker is idle are all strays.
        plan_all(3);
        run_walk("pre_idle", 1'b0);
        n_stray = 0;
        npkt = $urandom_range(2, 5);
        base = cyc + 2;
        for (int k = 0; k < npkt; k++) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) begin
                b.at = base + i; b.tid = IW'($urandom); b.data = {$urandom, $urandom};
                b.last = (i == len - 1);
                beat_q.push_back(b);
            end
            base += len + $urandom_range(0, 2);
        end
        for (int i = 0; i < 100 && beat_q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("idle_stray_count", 64'(n_stray), 64'(npkt));
        check("idle_done_held", 64'(done), 64'd1);
        check("idle_no_write", 64'(got_wr.size()), 64'(exp_wr.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
